// File: rtl/sync_buffer.sv
// Single-clock FIFO between the producer-select FSM and the display/parity path, drained at a paced rate.
// Latency: a word pushed into an empty buffer pops at the first pace tick at least one cycle after the push edge.
// Backpressure: buffer_full stops pushes, and a write while full is dropped and sets sticky overflow; pops wait for a tick.
module sync_buffer #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int RD_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_1_en,
    input  logic [WIDTH-1:0] data_1,
    output logic             buffer_full,
    output logic             buffer_empty,
    output logic             data_2_valid,
    output logic [WIDTH-1:0] data_2,
    output logic [AW:0]      count,
    output logic             overflow
);

    localparam int PW = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [PW-1:0] pace_t;

    localparam cnt_t  CNT_FULL  = cnt_t'(DEPTH);
    localparam cnt_t  CNT_ZERO  = cnt_t'(0);
    localparam cnt_t  CNT_ONE   = cnt_t'(1);
    localparam ptr_t  PTR_ONE   = ptr_t'(1);
    localparam pace_t PACE_LAST = pace_t'(RD_DIV - 1);
    localparam pace_t PACE_ONE  = pace_t'(1);

    // Storage is deliberately left out of reset; only pointers and count define validity.
    logic [WIDTH-1:0] mem [DEPTH];

    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    pace_t pace_cnt;
    logic  tick;
    logic  push;
    logic  pop;

    // Status flags decode the registered count, so they follow a push/pop by one cycle.
    always_comb begin
        buffer_full  = (count == CNT_FULL);
        buffer_empty = (count == CNT_ZERO);
    end

    // A tick lands on the last cycle of each pacing period; with RD_DIV = 1 every cycle ticks.
    always_comb begin
        tick = (pace_cnt == PACE_LAST);
        push = data_1_en & ~buffer_full;
        pop  = tick & ~buffer_empty;
    end

    // Free-running pace counter; a tick seen while empty is simply lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pace_cnt <= '0;
        end else if (tick) begin
            pace_cnt <= '0;
        end else begin
            pace_cnt <= pace_cnt + PACE_ONE;
        end
    end

    // Write side: store into the slot under wr_ptr; the pointer wraps naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_1;
        end
    end

    // Write pointer advances on every accepted push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Read side: register the oldest word and pulse valid for one cycle; data_2 holds between pops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            data_2       <= '0;
            data_2_valid <= 1'b0;
        end else begin
            data_2_valid <= pop;
            if (pop) begin
                data_2 <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy: simultaneous push and pop cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for any write attempted while full, even if a pop frees a slot on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (data_1_en && buffer_full) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_buffer.sv
// Randomized and directed bench for sync_buffer with two instances (RD_DIV = 4 and RD_DIV = 1).
// A queue-based reference model predicts every output each cycle.
// Inputs change on the falling edge, and outputs are compared on the following falling edge.
module tb_sync_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clock = 1'b0;
    logic reset;

    logic             en4, en1;
    logic [WIDTH-1:0] d4, d1;
    logic             full4, empty4, vld4, ovf4;
    logic             full1, empty1, vld1, ovf1;
    logic [WIDTH-1:0] q2_4, q2_1;
    logic [AW:0]      cnt4, cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    sync_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RD_DIV(4)) dut4 (
        .clock(clock), .reset(reset), .data_1_en(en4), .data_1(d4),
        .buffer_full(full4), .buffer_empty(empty4), .data_2_valid(vld4),
        .data_2(q2_4), .count(cnt4), .overflow(ovf4)
    );

    sync_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RD_DIV(1)) dut1 (
        .clock(clock), .reset(reset), .data_1_en(en1), .data_1(d1),
        .buffer_full(full1), .buffer_empty(empty1), .data_2_valid(vld1),
        .data_2(q2_1), .count(cnt1), .overflow(ovf1)
    );

    // Reference model state: index 0 models dut4, index 1 models dut1.
    logic [WIDTH-1:0] mq4 [$];
    logic [WIDTH-1:0] mq1 [$];
    int               m_cyc [2];
    logic             m_ovf [2];
    logic             m_vld [2];
    logic [WIDTH-1:0] m_d2  [2];
    int               pulses4;
    bit               seen_full4;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? mq4.size() : mq1.size();
    endfunction

    function automatic void model_reset();
        mq4.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            m_cyc[k] = 0;
            m_ovf[k] = 1'b0;
            m_vld[k] = 1'b0;
            m_d2[k]  = '0;
        end
    endfunction

    // One rising edge of the behavioural buffer: pops happen every RD_DIV-th cycle
    // after reset when something is stored; writes go in unless the buffer was full.
    function automatic void model_edge(input int k, input logic en, input logic [WIDTH-1:0] d);
        int rd;
        bit was_full;
        bit was_empty;
        rd        = (k == 0) ? 4 : 1;
        was_full  = (qsize(k) == DEPTH);
        was_empty = (qsize(k) == 0);
        m_vld[k]  = 1'b0;
        if ((m_cyc[k] % rd) == rd - 1 && !was_empty) begin
            m_vld[k] = 1'b1;
            if (k == 0) m_d2[k] = mq4.pop_front();
            else        m_d2[k] = mq1.pop_front();
        end
        if (en) begin
            if (was_full)    m_ovf[k] = 1'b1;
            else if (k == 0) mq4.push_back(d);
            else             mq1.push_back(d);
        end
        m_cyc[k]++;
    endfunction

    task automatic compare_all();
        chk("count4", 32'(cnt4), 32'(mq4.size()));
        chk("full4", 32'(full4), 32'(mq4.size() == DEPTH));
        chk("empty4", 32'(empty4), 32'(mq4.size() == 0));
        chk("valid4", 32'(vld4), 32'(m_vld[0]));
        chk("data2_4", 32'(q2_4), 32'(m_d2[0]));
        chk("ovf4", 32'(ovf4), 32'(m_ovf[0]));
        chk("count1", 32'(cnt1), 32'(mq1.size()));
        chk("full1", 32'(full1), 32'(mq1.size() == DEPTH));
        chk("empty1", 32'(empty1), 32'(mq1.size() == 0));
        chk("valid1", 32'(vld1), 32'(m_vld[1]));
        chk("data2_1", 32'(q2_1), 32'(m_d2[1]));
        chk("ovf1", 32'(ovf1), 32'(m_ovf[1]));
        if (vld4) pulses4++;
        if (full4) seen_full4 = 1'b1;
    endtask

    // Inputs are already stable; advance DUTs and model one edge, then compare.
    task automatic step();
        @(posedge clock);
        model_edge(0, en4, d4);
        model_edge(1, en1, d1);
        @(negedge clock);
        compare_all();
    endtask

    // Assert reset between edges, check the asynchronous clear, and release on a falling edge.
    task automatic do_reset(input string tag);
        @(negedge clock);
        en4 = 1'b0;
        en1 = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk({tag, "_cnt"}, 32'(cnt4), 32'd0);
        chk({tag, "_empty"}, 32'(empty4), 32'd1);
        chk({tag, "_full"}, 32'(full4), 32'd0);
        chk({tag, "_d2"}, 32'(q2_4), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf4), 32'd0);
        chk({tag, "_vld"}, 32'(vld4), 32'd0);
        chk({tag, "_cnt1"}, 32'(cnt1), 32'd0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int i;
        int guard;
        bit acc;
        reset = 1'b0;
        en4 = 1'b0; en1 = 1'b0; d4 = '0; d1 = '0;
        pulses4 = 0;
        seen_full4 = 1'b0;
        model_reset();
        do_reset("init");

        // Test 1: store words, then reset mid-run; nothing may pop afterwards.
        for (int v = 0; v < 7; v++) begin
            en4 = 1'b1; d4 = 16'(16'h0A00 + v);
            step();
        end
        en4 = 1'b0;
        chk("t1_stored", 32'(cnt4 >= 4), 32'd1);
        do_reset("t1_rst");
        pulses4 = 0;
        repeat (12) step();
        chk("t1_no_pulse", 32'(pulses4), 32'd0);

        // Test 2: a single word yields exactly one pulse.
        pulses4 = 0;
        en4 = 1'b1; d4 = 16'h0005;
        step();
        en4 = 1'b0;
        repeat (8) step();
        chk("t2_pulses", 32'(pulses4), 32'd1);
        chk("t2_data", 32'(q2_4), 32'h0005);

        // Test 3: fill past full; full and overflow must both appear.
        do_reset("t3_rst");
        seen_full4 = 1'b0;
        for (int v = 1; v <= 12; v++) begin
            en4 = 1'b1; d4 = 16'(v);
            step();
        end
        en4 = 1'b0;
        repeat (40) step();
        chk("t3_full_seen", 32'(seen_full4), 32'd1);
        chk("t3_ovf", 32'(ovf4), 32'd1);

        // Test 4: 20 words with intermittent writes across several pointer wraps.
        do_reset("t4_rst");
        i = 0;
        guard = 0;
        while (i < 20 && guard < 500) begin
            en4 = 1'($urandom_range(0, 1));
            d4 = 16'(16'h0100 + i);
            acc = en4 && (mq4.size() < DEPTH);
            step();
            if (acc) i++;
            guard++;
        end
        chk("t4_all_sent", 32'(i), 32'd20);
        en4 = 1'b0;
        repeat (40) step();
        chk("t4_last", 32'(q2_4), 32'h0113);

        // Test 5: with three stored, write on a tick cycle; occupancy holds.
        do_reset("t5_rst");
        for (int v = 1; v <= 4; v++) begin
            en4 = 1'b1; d4 = 16'(16'h0500 + v);
            step();
        end
        en4 = 1'b0;
        chk("t5_cnt", 32'(cnt4), 32'd3);
        chk("t5_d2", 32'(q2_4), 32'h0501);
        repeat (20) step();
        chk("t5_drain", 32'(q2_4), 32'h0504);

        // Test 6: RD_DIV = 1 streaming keeps occupancy at most one.
        for (int v = 0; v < 16; v++) begin
            en1 = 1'b1; d1 = 16'(v);
            step();
            chk("t6_cnt_le1", 32'(cnt1 <= 1), 32'd1);
        end
        en1 = 1'b0;
        repeat (4) step();
        chk("t6_last", 32'(q2_1), 32'd15);
        chk("t6_ovf", 32'(ovf1), 32'd0);

        // Random traffic on both instances, including bursts that overflow.
        do_reset("rnd_rst");
        for (int c = 0; c < 400; c++) begin
            en4 = ($urandom_range(0, 99) < 45);
            en1 = ($urandom_range(0, 99) < 70);
            d4 = 16'($urandom);
            d1 = 16'($urandom);
            step();
        end
        en4 = 1'b0; en1 = 1'b0;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
